// File: rtl/run_ctrl_pkg.sv
// Shared types for the MIPS run controller: FSM states and fail codes.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } run_state_e;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_DATA    = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd2;
    localparam logic [1:0] FAIL_STALL   = 2'd3;

endpackage

// File: rtl/pc_stall_detector.sv
// Flags a hang once pc has stayed unchanged for STALL_LIMIT consecutive enabled cycles.
module pc_stall_detector #(
    parameter int DATA_W      = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] pc,
    output logic              stalled
);

    localparam int              SW  = $clog2(STALL_LIMIT);
    localparam logic [SW-1:0]   SAT = SW'(STALL_LIMIT - 1);

    logic [DATA_W-1:0] prev_q;
    logic              vld_q;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              same;

    // The first enabled cycle has no previous pc to compare against.
    assign same    = vld_q && (pc == prev_q);
    assign stalled = same && (cnt_q == SAT);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || !same) begin
            cnt_d = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= '0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= pc;
            vld_q  <= en;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences core reset, counts RUN cycles and decides pass/fail from the
// signature store, a PC stall or a timeout.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          RESET_CYCLES = 4,
    parameter int          TIMEOUT      = 1000,
    parameter int          STALL_LIMIT  = 16,
    parameter int          CNT_W        = 16,
    parameter int unsigned PASS_ADDR    = 84,
    parameter int unsigned PASS_DATA    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pc,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] last_pc
);

    localparam int              RW     = $clog2(RESET_CYCLES + 1);
    localparam logic [RW-1:0]   RLAST  = RW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);

    run_state_e        state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        fail_q, fail_d;
    logic [DATA_W-1:0] lpc_q, lpc_d;
    logic [1:0]        rel_q;
    logic              stalled;
    logic              sig_store;

    // Reset release is delayed two cycles; IDLE may not be left until it completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rel_q <= '0;
        else        rel_q <= {rel_q[0], 1'b1};
    end

    pc_stall_detector #(
        .DATA_W      (DATA_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q == ST_RUN),
        .pc      (pc),
        .stalled (stalled)
    );

    assign sig_store = memwrite && (dataadr == DATA_W'(PASS_ADDR));

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        count_d = count_q;
        fail_d  = fail_q;
        lpc_d   = lpc_q;
        unique case (state_q)
            ST_IDLE:  if (start && rel_q[1]) state_d = ST_RESET;
            ST_RESET: begin
                if (rcnt_q == RLAST) state_d = ST_RUN;
                else                 rcnt_d  = rcnt_q + 1'b1;
            end
            ST_RUN: begin
                count_d = count_q + 1'b1;
                if (sig_store && (writedata == DATA_W'(PASS_DATA))) begin
                    state_d = ST_PASS;
                    lpc_d   = pc;
                end else if (sig_store) begin
                    state_d = ST_FAIL;
                    fail_d  = FAIL_DATA;
                    lpc_d   = pc;
                end else if (stalled) begin
                    state_d = ST_FAIL;
                    fail_d  = FAIL_STALL;
                    lpc_d   = pc;
                end else if (count_q == TLAST) begin
                    state_d = ST_FAIL;
                    fail_d  = FAIL_TIMEOUT;
                    lpc_d   = pc;
                end
            end
            ST_PASS, ST_FAIL: if (start) state_d = ST_RESET;
            default:  state_d = ST_IDLE;
        endcase
        // Every entry into RESET starts a fresh run with cleared results.
        if (state_d == ST_RESET && state_q != ST_RESET) begin
            rcnt_d  = '0;
            count_d = '0;
            fail_d  = FAIL_NONE;
            lpc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            count_q <= '0;
            fail_q  <= FAIL_NONE;
            lpc_q   <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            count_q <= count_d;
            fail_q  <= fail_d;
            lpc_q   <= lpc_d;
        end
    end

    assign core_reset  = (state_q != ST_RUN);
    assign busy        = (state_q == ST_RESET) || (state_q == ST_RUN);
    assign done        = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass        = (state_q == ST_PASS);
    assign fail_code   = fail_q;
    assign cycle_count = count_q;
    assign last_pc     = lpc_q;

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run controller for the MIPS core. It sequences the core's reset, counts execution cycles and watches the core's data-memory write port for the pass signature: a store of `PASS_DATA` to `PASS_ADDR`. It declares pass or fail, with timeout and PC-stall detection, so regressions and FPGA runs need no testbench-side clock/reset scripting. It sits beside `main`, driving its `reset` and snooping `pc`, `memwrite`, `aluout` (data address) and `writedata`.

## Interface
- `DATA_W`, 32: width of `writedata`/`pc`/address buses.
- `RESET_CYCLES`, 4: cycles `core_reset` is held in RESET; legal range ≥1.
- `TIMEOUT`, 1000: maximum RUN cycles before fail; legal range ≥2.
- `STALL_LIMIT`, 16: consecutive RUN cycles with unchanged `pc` that count as a hang; legal range ≥2.
- `CNT_W`, 16: width of `cycle_count`; must satisfy 2^CNT_W > TIMEOUT.
- `PASS_ADDR`, 84: signature store address.
- `PASS_DATA`, 7: signature store data.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low controller reset.
- `start`  in  1  level-sampled run request.
- `pc`  in  DATA_W  core program counter.
- `memwrite`  in  1  core store strobe.
- `dataadr`  in  DATA_W  core store address (`aluout`).
- `writedata`  in  DATA_W  core store data.
- `core_reset`  out  1  active-high reset to the core.
- `busy`  out  1  high in RESET and RUN.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  high in PASS only.
- `fail_code`  out  2  0 none, 1 bad signature data, 2 timeout, 3 PC stall.
- `cycle_count`  out  CNT_W  RUN cycles elapsed.
- `last_pc`  out  DATA_W  `pc` captured on the terminating cycle.

## Operation
- States: IDLE, RESET, RUN, PASS, FAIL.
- IDLE: `core_reset`=1. Leaves on `start`=1 → RESET.
- RESET: `core_reset`=1 for exactly RESET_CYCLES cycles, then → RUN. Clears `cycle_count`, `fail_code`, `last_pc` and the stall counter on entry.
- RUN: `core_reset`=0. `cycle_count` increments every cycle. Exits are checked in priority order each cycle:
  - `memwrite` & `dataadr`==PASS_ADDR & `writedata`==PASS_DATA → PASS.
  - `memwrite` & `dataadr`==PASS_ADDR with other data → FAIL, code 1.
  - stall counter reaches STALL_LIMIT−1 with `pc` unchanged → FAIL, code 3.
  - `cycle_count`==TIMEOUT−1 → FAIL, code 2.
  - Signature therefore beats stall, and stall beats timeout, when they coincide.
- Stall counter: counts consecutive RUN cycles where `pc` equals the previous cycle's `pc`; any change clears it to 0.
- PASS/FAIL: `core_reset`=1 and all results held. `start`=1 → RESET (rerun). `start` is ignored in RESET and RUN.
- Stores to addresses other than PASS_ADDR are ignored.
- Asserting `reset` low at any time, including mid-RUN, forces IDLE immediately.
- Reset values: `core_reset`=1, `busy`=0, `done`=0, `pass`=0, `fail_code`=0, `cycle_count`=0, `last_pc`=0.
- `cycle_count` never wraps; TIMEOUT bounds it.

## Timing
- All outputs are registered or decoded from the state register only.
- `start` high at edge N (IDLE) → RESET from N+1. `core_reset` falls at edge N+RESET_CYCLES.
- A terminating condition sampled at edge M → `done`, `pass`/`fail_code` and `last_pc` are valid, and `core_reset` rises, from M+1.
- `cycle_count` equals the number of RUN cycles including the terminating one.
- `reset` deassertion is synchronised internally through a 2-flop release; the controller stays in IDLE for 2 cycles after release.

## Structure
- Package `run_ctrl_pkg` holds:
  - the state enum;
  - fail code constants FAIL_NONE/FAIL_DATA/FAIL_TIMEOUT/FAIL_STALL.
- Sub-module `pc_stall_detector` holds the previous-`pc` register and saturating counter, parameterised by DATA_W and STALL_LIMIT, with output `stalled`.

## Test plan
- Reset: `reset`=0 → `core_reset`=1, all other outputs 0; after release with `start`=0 the controller stays in IDLE indefinitely.
- Pass: `start` pulse, core stores 7 to 84 on RUN cycle 20 → `pass`=1, `done`=1, `fail_code`=0, `cycle_count`=20, `core_reset`=1 next cycle.
- Bad data: store 5 to 84 → `fail_code`=1; simultaneous store to 80 is ignored.
- Timeout (TIMEOUT=50): no signature, `pc` toggles → `fail_code`=2, `cycle_count`=50.
- Stall (STALL_LIMIT=16): `pc` frozen at 0x3C → `fail_code`=3 after 16 unchanged cycles, `last_pc`=0x3C. Signature on the same cycle → PASS instead.
- Mid-run reset: `reset` low at RUN cycle 10 → immediate IDLE with reset values. Rerun from PASS via `start` → counters cleared, fresh RESET of RESET_CYCLES.
